siren_sequencer: RTL
====================

// Module: siren_sequencer
// PURPOSE
//   Downstream of the anti-theft FSM. Consumes its 3-bit state code and siren request (led[1]).
//   Drives the physical siren/horn output as an audible square wave:
//     - single chirp on auto-arm
//     - double chirp on disarm
//     - two-tone warble while the alarm sounds
//   Also emits one-cycle arm/disarm event pulses for status logging.
// PARAMETERS
//   TONE_DIV   4   clocks per half-period of the base tone (warble low tone uses 2*TONE_DIV); >=2
//   BEAT_DIV   5   clocks per beat: chirp-on, chirp-gap and warble-step length; >=2
// PORTS
//   clk          in   1  system clock; single clock domain
//   reset        in   1  asynchronous, active-high; clears all state
//   fsm_state    in   3  anti-theft FSM state (000 armed ... 111 disarmed+driver off), synchronous to clk
//   siren_req    in   1  alarm-sounding request from the FSM (its siren LED), synchronous
//   siren_out    out  1  registered tone output to the siren driver
//   chirp_busy   out  1  high while a chirp sequence (ON or GAP) is in progress
//   arm_evt      out  1  one-cycle pulse: arm chirp started
//   disarm_evt   out  1  one-cycle pulse: disarm chirp started
// BEHAVIOUR
//   Reset: siren_out=0, chirp_busy=0, arm_evt=0, disarm_evt=0, seq=IDLE, prev_state=000, all counters 0.
//   Edge detect: prev_state <= fsm_state every cycle. An event is decoded combinationally in cycle N.
//     ARM    = prev_state==111 && fsm_state==000. Entry to 000 from 011, from reset, or by reprogram: no event.
//     DISARM = prev_state in {000,001,010} && fsm_state==100.
//   Sequencer states: IDLE, CHIRP_ON, CHIRP_GAP, ALARM.
//     Event in cycle N -> in cycle N+1: matching *_evt=1 for exactly one cycle, seq=CHIRP_ON,
//       beat_cnt=0, tone_cnt=0, phase=0.
//       beats_left=0 for ARM, 1 for DISARM.
//     CHIRP_ON  lasts BEAT_DIV clocks. Then:
//       beats_left==0 -> IDLE
//       else          -> CHIRP_GAP
//     CHIRP_GAP lasts BEAT_DIV clocks, siren_out=0. Then: beats_left-=1, -> CHIRP_ON.
//     Total duration: ARM = BEAT_DIV cycles; DISARM = 3*BEAT_DIV cycles (on, gap, on).
//     chirp_busy=1 exactly while seq is CHIRP_ON or CHIRP_GAP.
//   Tone generation (CHIRP_ON and ALARM only):
//     tone_cnt counts 0..div-1; at div-1 it wraps to 0 and phase toggles. siren_out=phase.
//     CHIRP_ON: div=TONE_DIV.
//     ALARM: div alternates TONE_DIV / 2*TONE_DIV; warble_sel toggles every BEAT_DIV clocks, starting at TONE_DIV.
//     On entry to any state, phase=0 and tone_cnt=0. siren_out=0 in IDLE and CHIRP_GAP.
//   ALARM entry/exit:
//     siren_req=1 in any state -> ALARM next cycle; any chirp in progress is aborted (chirp_busy->0).
//     siren_req=0 while in ALARM -> IDLE next cycle, siren_out=0; no chirp unless an event fires in that same cycle.
//   Priority (same cycle): siren_req > DISARM > ARM.
//     An event during a chirp restarts the sequence from CHIRP_ON with the new beats_left
//     (a new *_evt pulse is issued).
//   Widths: tone_cnt is clog2(2*TONE_DIV) bits, beat_cnt is clog2(BEAT_DIV) bits, beats_left is 1 bit.
//     No counter may wrap other than at its terminal value.
//   Reset asserted mid-sequence: all outputs 0 immediately (asynchronous); after release, seq=IDLE
//     and prev_state=000, so a first fsm_state of 000 produces no event.
// TESTING
//   1 fsm_state 111->000 at cycle 10 (defaults) -> arm_evt=1 @11 only; siren_out toggles every 4 clks
//     for 5 clks (high @15); chirp_busy 11..15; IDLE @16.
//   2 fsm_state 001->100 -> disarm_evt 1 cycle; chirp_busy 15 cycles; siren_out 0 during cycles 6..10
//     of the sequence; ON/GAP/ON of 5 clks each.
//   3 siren_req=1 held 40 clks -> siren_out half-period 4 clks for 5 clks, then 8 clks for 5 clks,
//     alternating; siren_req=0 -> siren_out=0 next cycle.
//   4 siren_req rises during disarm gap -> chirp_busy drops next cycle, ALARM warble starts with phase=0,
//     no evt pulse.
//   5 011->000 and reset release with fsm_state=000 -> no arm_evt, siren_out stays 0.
//   6 reset pulsed mid-chirp (async, off clock edge) -> all outputs 0 same instant; IDLE after release.

Source files
------------

// File: rtl/siren_sequencer.sv
// siren_sequencer
//   Turns the anti-theft FSM state code and its siren request into an audible
//   square wave for the siren driver: a single chirp on auto-arm, a double
//   chirp on disarm, and a two-tone warble while the alarm is sounding.
//   It also emits one-cycle arm/disarm event pulses for status logging.
//   Every output comes straight from a flop.
module siren_sequencer #(
  parameter int TONE_DIV = 4,  // clocks per half-period of the base tone (>=2)
  parameter int BEAT_DIV = 5   // clocks per beat: chirp-on, chirp-gap, warble step (>=2)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] fsm_state,
  input  logic       siren_req,
  output logic       siren_out,
  output logic       chirp_busy,
  output logic       arm_evt,
  output logic       disarm_evt
);

  localparam int TW = $clog2(2 * TONE_DIV);
  localparam int BW = $clog2(BEAT_DIV);

  // Terminal counts.
  // The warble high tone uses TONE_DIV clocks per half-period.
  // The warble low tone uses 2*TONE_DIV clocks per half-period.
  localparam logic [TW-1:0] TONE_LO_LAST = TW'(TONE_DIV - 1);
  localparam logic [TW-1:0] TONE_HI_LAST = TW'(2 * TONE_DIV - 1);
  localparam logic [TW-1:0] TONE_ZERO    = TW'(0);
  localparam logic [TW-1:0] TONE_ONE     = TW'(1);
  localparam logic [BW-1:0] BEAT_LAST    = BW'(BEAT_DIV - 1);
  localparam logic [BW-1:0] BEAT_ZERO    = BW'(0);
  localparam logic [BW-1:0] BEAT_ONE     = BW'(1);

  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_CHIRP_ON  = 2'd1,
    SEQ_CHIRP_GAP = 2'd2,
    SEQ_ALARM     = 2'd3
  } seq_e;

  // State registers
  seq_e          seq_r;
  logic [2:0]    prev_state_r;
  logic [TW-1:0] tone_cnt_r;
  logic [BW-1:0] beat_cnt_r;
  logic          beats_left_r;
  logic          phase_r;
  logic          warble_sel_r;
  logic          chirp_busy_r;
  logic          arm_evt_r;
  logic          disarm_evt_r;

  // Next-state values
  seq_e          seq_s;
  logic [TW-1:0] tone_cnt_s;
  logic [BW-1:0] beat_cnt_s;
  logic          beats_left_s;
  logic          phase_s;
  logic          warble_sel_s;
  logic          arm_evt_s;
  logic          disarm_evt_s;

  // Decode helpers
  logic          arm_hit_s;
  logic          disarm_hit_s;
  logic [TW-1:0] tone_last_s;
  logic          tone_wrap_s;
  logic          beat_end_s;

  // Event decode.
  // Arm is only the 111 -> 000 transition (auto-arm after disarmed + driver off).
  // Entry to 000 from any other state, or from reset, is not an arm event.
  assign arm_hit_s    = (prev_state_r == 3'b111) && (fsm_state == 3'b000);
  assign disarm_hit_s = (fsm_state == 3'b100) &&
                        ((prev_state_r == 3'b000) ||
                         (prev_state_r == 3'b001) ||
                         (prev_state_r == 3'b010));

  // The tone divider selects the low (2x) half-period only while warbling
  // with warble_sel set.
  assign tone_last_s = ((seq_r == SEQ_ALARM) && warble_sel_r) ? TONE_HI_LAST : TONE_LO_LAST;

  // Greater-or-equal wrap.
  // When the warble switches from the long divider to the short one,
  // tone_cnt may already be past the new terminal value.
  // In that case it wraps immediately instead of rolling over the counter width.
  assign tone_wrap_s = (tone_cnt_r >= tone_last_s);
  assign beat_end_s  = (beat_cnt_r == BEAT_LAST);

  // Outputs are the registered phase/busy/event flops.
  // phase_r is held at 0 outside CHIRP_ON and ALARM.
  assign siren_out  = phase_r;
  assign chirp_busy = chirp_busy_r;
  assign arm_evt    = arm_evt_r;
  assign disarm_evt = disarm_evt_r;

  // Next-state logic.
  // Priority is siren_req, then disarm, then arm, then normal sequencing.
  always_comb begin
    seq_s        = seq_r;
    tone_cnt_s   = tone_cnt_r;
    beat_cnt_s   = beat_cnt_r;
    beats_left_s = beats_left_r;
    phase_s      = phase_r;
    warble_sel_s = warble_sel_r;
    arm_evt_s    = 1'b0;
    disarm_evt_s = 1'b0;

    if (siren_req) begin
      if (seq_r == SEQ_ALARM) begin
        // Keep warbling: advance the tone divider and the warble step timer.
        if (tone_wrap_s) begin
          tone_cnt_s = TONE_ZERO;
          phase_s    = ~phase_r;
        end else begin
          tone_cnt_s = tone_cnt_r + TONE_ONE;
        end
        if (beat_end_s) begin
          beat_cnt_s   = BEAT_ZERO;
          warble_sel_s = ~warble_sel_r;
        end else begin
          beat_cnt_s = beat_cnt_r + BEAT_ONE;
        end
      end else begin
        // Enter ALARM from anywhere and abort any chirp.
        // No event pulse is issued.
        seq_s        = SEQ_ALARM;
        tone_cnt_s   = TONE_ZERO;
        beat_cnt_s   = BEAT_ZERO;
        phase_s      = 1'b0;
        warble_sel_s = 1'b0;
        beats_left_s = 1'b0;
      end
    end else if (disarm_hit_s) begin
      // Double chirp: ON, GAP, ON.
      seq_s        = SEQ_CHIRP_ON;
      tone_cnt_s   = TONE_ZERO;
      beat_cnt_s   = BEAT_ZERO;
      phase_s      = 1'b0;
      warble_sel_s = 1'b0;
      beats_left_s = 1'b1;
      disarm_evt_s = 1'b1;
    end else if (arm_hit_s) begin
      // Single chirp.
      seq_s        = SEQ_CHIRP_ON;
      tone_cnt_s   = TONE_ZERO;
      beat_cnt_s   = BEAT_ZERO;
      phase_s      = 1'b0;
      warble_sel_s = 1'b0;
      beats_left_s = 1'b0;
      arm_evt_s    = 1'b1;
    end else begin
      case (seq_r)
        SEQ_IDLE: begin
          seq_s = SEQ_IDLE;
        end
        SEQ_CHIRP_ON: begin
          if (beat_end_s) begin
            if (beats_left_r == 1'b0) begin
              seq_s = SEQ_IDLE;
            end else begin
              seq_s = SEQ_CHIRP_GAP;
            end
            tone_cnt_s = TONE_ZERO;
            beat_cnt_s = BEAT_ZERO;
            phase_s    = 1'b0;
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
            if (tone_wrap_s) begin
              tone_cnt_s = TONE_ZERO;
              phase_s    = ~phase_r;
            end else begin
              tone_cnt_s = tone_cnt_r + TONE_ONE;
            end
          end
        end
        SEQ_CHIRP_GAP: begin
          if (beat_end_s) begin
            seq_s        = SEQ_CHIRP_ON;
            beats_left_s = beats_left_r - 1'b1;
            tone_cnt_s   = TONE_ZERO;
            beat_cnt_s   = BEAT_ZERO;
            phase_s      = 1'b0;
          end else begin
            beat_cnt_s = beat_cnt_r + BEAT_ONE;
          end
        end
        SEQ_ALARM: begin
          // siren_req has dropped: go silent.
          seq_s        = SEQ_IDLE;
          tone_cnt_s   = TONE_ZERO;
          beat_cnt_s   = BEAT_ZERO;
          phase_s      = 1'b0;
          warble_sel_s = 1'b0;
        end
        default: begin
          seq_s        = SEQ_IDLE;
          tone_cnt_s   = TONE_ZERO;
          beat_cnt_s   = BEAT_ZERO;
          phase_s      = 1'b0;
          warble_sel_s = 1'b0;
          beats_left_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_r        <= SEQ_IDLE;
      tone_cnt_r   <= TONE_ZERO;
      beat_cnt_r   <= BEAT_ZERO;
      beats_left_r <= 1'b0;
      phase_r      <= 1'b0;
      warble_sel_r <= 1'b0;
    end else begin
      seq_r        <= seq_s;
      tone_cnt_r   <= tone_cnt_s;
      beat_cnt_r   <= beat_cnt_s;
      beats_left_r <= beats_left_s;
      phase_r      <= phase_s;
      warble_sel_r <= warble_sel_s;
    end
  end

  // Previous FSM state for edge detection.
  // It resets to 000, so a first 000 after reset is not an arm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state_r <= 3'b000;
    end else begin
      prev_state_r <= fsm_state;
    end
  end

  // Registered status outputs: busy flag and one-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chirp_busy_r <= 1'b0;
      arm_evt_r    <= 1'b0;
      disarm_evt_r <= 1'b0;
    end else begin
      chirp_busy_r <= (seq_s == SEQ_CHIRP_ON) || (seq_s == SEQ_CHIRP_GAP);
      arm_evt_r    <= arm_evt_s;
      disarm_evt_r <= disarm_evt_s;
    end
  end

endmodule
